// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler: read-priority DRAM command scheduler with watermark write drain and RAW blocking
module dram_cmd_scheduler #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int WR_HI  = 6,
  parameter int WR_LO  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_issue_valid,
  input  logic              i_issue_ready,
  output logic              o_issue_write,
  output logic [ADDR_W-1:0] o_issue_addr,
  output logic [DATA_W-1:0] o_issue_data,
  output logic [15:0]       o_wr_issued,
  output logic [15:0]       o_rd_issued,
  output logic [15:0]       o_raw_count,
  output logic              o_drain
);
  localparam int L = $clog2(DEPTH);
  localparam int P = L + 1;
  typedef enum logic {RD_PRIO, WR_DRAIN} state_t;
  logic [ADDR_W-1:0] rq_addr [DEPTH];
  logic [ADDR_W-1:0] wq_addr [DEPTH];
  logic [DATA_W-1:0] wq_data [DEPTH];
  logic [P-1:0] rq_wp, rq_rp, wq_wp, wq_rp, rq_cnt, wq_cnt;
  logic [L-1:0] ofs;
  logic rq_empty, wq_empty, rq_full, wq_full;
  logic acc, rq_push, wq_push, rq_pop, wq_pop, hs;
  logic blk_hit, new_hit, rd_blk, pick_rd, pick_wr, sel_valid, sel_write;
  logic lock, lock_write;
  logic [ADDR_W-1:0] rq_head, wq_head;
  state_t state, state_nx;
  assign rq_cnt = rq_wp - rq_rp;
  assign wq_cnt = wq_wp - wq_rp;
  assign rq_empty = rq_wp == rq_rp;
  assign wq_empty = wq_wp == wq_rp;
  assign rq_full = rq_wp[L] != rq_rp[L] && rq_wp[L-1:0] == rq_rp[L-1:0];
  assign wq_full = wq_wp[L] != wq_rp[L] && wq_wp[L-1:0] == wq_rp[L-1:0];
  assign o_cmd_ready = !rq_full && !wq_full;
  assign acc = i_cmd_valid && o_cmd_ready;
  assign rq_push = acc && !i_cmd_write;
  assign wq_push = acc && i_cmd_write;
  assign rq_head = rq_addr[rq_rp[L-1:0]];
  assign wq_head = wq_addr[wq_rp[L-1:0]];
  // Address match against every live write entry, for both the read head and an arriving read
  always_comb begin
    blk_hit = 1'b0;
    new_hit = 1'b0;
    ofs = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ofs = L'(k) - wq_rp[L-1:0];
      if ({1'b0, ofs} < wq_cnt) begin
        blk_hit = blk_hit | (wq_addr[k] == rq_head);
        new_hit = new_hit | (wq_addr[k] == i_cmd_addr);
      end
    end
  end
  assign rd_blk = !rq_empty && blk_hit;
  assign pick_rd = state == RD_PRIO && !rq_empty && !rd_blk;
  assign pick_wr = !pick_rd && !wq_empty;
  assign sel_valid = lock || pick_rd || pick_wr;
  assign sel_write = lock ? lock_write : pick_wr;
  assign hs = sel_valid && i_issue_ready;
  assign rq_pop = hs && !sel_write;
  assign wq_pop = hs && sel_write;
  assign o_issue_valid = sel_valid;
  assign o_issue_write = sel_valid && sel_write;
  assign o_issue_addr = !sel_valid ? '0 : sel_write ? wq_head : rq_head;
  assign o_issue_data = (sel_valid && sel_write) ? wq_data[wq_rp[L-1:0]] : '0;
  assign o_drain = state == WR_DRAIN;
  // Drain entry/exit decided from pre-edge queue occupancy
  always_comb begin
    state_nx = state;
    if (state == RD_PRIO)
      state_nx = (wq_cnt >= P'(WR_HI) || (rd_blk && !wq_empty)) ? WR_DRAIN : RD_PRIO;
    else
      state_nx = ((wq_cnt <= P'(WR_LO) && !rd_blk) || wq_empty) ? RD_PRIO : WR_DRAIN;
  end
  // Queue storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge i_clk) begin
    if (rq_push) rq_addr[rq_wp[L-1:0]] <= i_cmd_addr;
    if (wq_push) begin
      wq_addr[wq_wp[L-1:0]] <= i_cmd_addr;
      wq_data[wq_wp[L-1:0]] <= i_cmd_data;
    end
  end
  // Pointers, FSM, issue lock and statistics counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rq_wp <= '0;
      rq_rp <= '0;
      wq_wp <= '0;
      wq_rp <= '0;
      state <= RD_PRIO;
      lock <= 1'b0;
      lock_write <= 1'b0;
      o_wr_issued <= '0;
      o_rd_issued <= '0;
      o_raw_count <= '0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + 1'b1;
      if (wq_push) wq_wp <= wq_wp + 1'b1;
      if (rq_pop) rq_rp <= rq_rp + 1'b1;
      if (wq_pop) wq_rp <= wq_rp + 1'b1;
      state <= state_nx;
      lock <= sel_valid && !i_issue_ready;
      if (!lock) lock_write <= sel_write;
      if (wq_pop) o_wr_issued <= o_wr_issued + 1'b1;
      if (rq_pop) o_rd_issued <= o_rd_issued + 1'b1;
      if (rq_push && new_hit) o_raw_count <= o_raw_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb_dram_cmd_scheduler: scoreboard bench for the read/write command scheduler
module tb_dram_cmd_scheduler;
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [63:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic issue_valid, issue_ready = 1'b0, issue_write;
  logic [31:0] issue_addr;
  logic [63:0] issue_data;
  logic [15:0] wr_issued, rd_issued, raw_count;
  logic drain;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  dram_cmd_scheduler dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
    .o_issue_valid(issue_valid), .i_issue_ready(issue_ready), .o_issue_write(issue_write),
    .o_issue_addr(issue_addr), .o_issue_data(issue_data),
    .o_wr_issued(wr_issued), .o_rd_issued(rd_issued), .o_raw_count(raw_count),
    .o_drain(drain)
  );
  function automatic logic [63:0] wdata(input logic [31:0] a);
    return {32'hDA7A_0000, a};
  endfunction
  function automatic void exp_w(input logic [31:0] a);
    exp_q.push_back('{w: 1'b1, a: a, d: wdata(a)});
  endfunction
  function automatic void exp_r(input logic [31:0] a);
    exp_q.push_back('{w: 1'b0, a: a, d: 64'h0});
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic w, input logic [31:0] a);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_data = w ? wdata(a) : 64'h0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 addr %0h", a);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic drain_all(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step(1);
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask
  // Scoreboard monitor: every handshake must match the next expected command
  always @(negedge clk) begin
    exp_t e;
    if (!rst && issue_valid && issue_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue: got w=%0b addr=%0h expected none", issue_write, issue_addr);
      end else begin
        e = exp_q.pop_front();
        if ({issue_write, issue_addr, issue_data} !== e) begin
          failures++;
          $display("FAIL issue: got w=%0b addr=%0h data=%0h expected w=%0b addr=%0h data=%0h",
                   issue_write, issue_addr, issue_data, e.w, e.a, e.d);
        end
      end
    end
  end
  initial begin
    step(2);
    rst = 1'b0;
    chk("por_valid", 64'(issue_valid), 64'd0);
    chk("por_ready", 64'(cmd_ready), 64'd1);
    // reset mid-traffic
    issue_ready = 1'b1;
    exp_w(32'h1);
    send(1'b1, 32'h1);
    drain_all("t1_drain");
    chk("t1_wr_pre", 64'(wr_issued), 64'd1);
    issue_ready = 1'b0;
    send(1'b0, 32'h2);
    send(1'b1, 32'h3);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_drain", 64'(drain), 64'd0);
    chk("rst_addr", 64'(issue_addr), 64'd0);
    chk("rst_cnts", {16'h0, wr_issued, rd_issued, raw_count}, 64'd0);
    // read priority over an older queued write
    exp_w(32'h08);
    exp_r(32'h20);
    exp_w(32'h10);
    send(1'b1, 32'h08);
    send(1'b1, 32'h10);
    send(1'b0, 32'h20);
    issue_ready = 1'b1;
    drain_all("t2_drain");
    chk("t2_rd", 64'(rd_issued), 64'd1);
    chk("t2_wr", 64'(wr_issued), 64'd2);
    // RAW hazard forces write drain
    issue_ready = 1'b0;
    exp_w(32'h40);
    exp_r(32'h40);
    send(1'b1, 32'h40);
    send(1'b0, 32'h40);
    step(2);
    chk("t3_raw", 64'(raw_count), 64'd1);
    chk("t3_drain", 64'(drain), 64'd1);
    issue_ready = 1'b1;
    drain_all("t3_drain_q");
    chk("t3_drain_end", 64'(drain), 64'd0);
    // watermark drain: exits after the cycle that sees two writes left
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) exp_w(32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) exp_r(32'h200 + 32'(i));
    exp_w(32'h105);
    for (int i = 0; i < 6; i++) send(1'b1, 32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) send(1'b0, 32'h200 + 32'(i));
    chk("t4_drain_on", 64'(drain), 64'd1);
    issue_ready = 1'b1;
    drain_all("t4_drain_q");
    chk("t4_drain_off", 64'(drain), 64'd0);
    chk("t4_wr", 64'(wr_issued), 64'd9);
    chk("t4_rd", 64'(rd_issued), 64'd6);
    // full read queue with backpressure, pointer wrap
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_r(32'h300 + 32'(i * 4));
      send(1'b0, 32'h300 + 32'(i * 4));
    end
    chk("t5_full", 64'(cmd_ready), 64'd0);
    chk("t5_head0", 64'(issue_addr), 64'h300);
    step(3);
    chk("t5_head1", 64'(issue_addr), 64'h300);
    chk("t5_valid", 64'(issue_valid), 64'd1);
    issue_ready = 1'b1;
    drain_all("t5_drain_q");
    chk("t5_rd", 64'(rd_issued), 64'd14);
    chk("t5_ready", 64'(cmd_ready), 64'd1);
    // lock holds a presented write against a later read
    issue_ready = 1'b0;
    exp_w(32'h600);
    exp_r(32'h700);
    send(1'b1, 32'h600);
    send(1'b0, 32'h700);
    step(2);
    chk("t6_write", 64'(issue_write), 64'd1);
    chk("t6_addr", 64'(issue_addr), 64'h600);
    chk("t6_data", issue_data, wdata(32'h600));
    issue_ready = 1'b1;
    drain_all("t6_drain_q");
    chk("end_wr", 64'(wr_issued), 64'd10);
    chk("end_rd", 64'(rd_issued), 64'd15);
    chk("end_raw", 64'(raw_count), 64'd1);
    chk("end_idle", 64'(issue_valid), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
